// File: rtl/ddc_out_framer_pkg.sv
// Shared types, default widths and helpers for the DDC output framer.
package ddc_out_framer_pkg;

  localparam int SAMP_W_DEF  = 32;
  localparam int SPP_W_DEF   = 16;
  localparam int DECIM_W_DEF = 16;
  localparam int TIME_W_DEF  = 64;

  typedef enum logic {ST_IDLE, ST_BURST} framer_state_t;

  // A decimation rate of zero would freeze the timestamp; treat it as one.
  function automatic logic [31:0] sat_decim(input logic [31:0] decim);
    return (decim == 32'd0) ? 32'd1 : decim;
  endfunction

endpackage

// File: rtl/ddc_out_framer_skid.sv
// Generic 2-entry AXI-Stream skid buffer; the first entry is the registered output stage.
module ddc_out_framer_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic [W-1:0] out_data_reg, out_data_next, sk_data_reg, sk_data_next;
  logic         out_valid_reg, out_valid_next, sk_valid_reg, sk_valid_next;
  logic         ready_reg, in_fire;

  assign in_fire = s_valid && ready_reg;
  assign s_ready = ready_reg;
  assign m_data  = out_data_reg;
  assign m_valid = out_valid_reg;

  // ready_reg is the registered complement of the skid slot, so a beat can
  // only land in the skid while the output stage is stalled.
  always_comb begin
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    sk_data_next   = sk_data_reg;
    sk_valid_next  = sk_valid_reg;
    if (clear) begin
      out_valid_next = 1'b0;
      sk_valid_next  = 1'b0;
    end else if (!out_valid_reg || m_ready) begin
      if (sk_valid_reg) begin
        out_valid_next = 1'b1;
        out_data_next  = sk_data_reg;
        sk_valid_next  = 1'b0;
      end else begin
        out_valid_next = in_fire;
        if (in_fire) out_data_next = s_data;
      end
    end else if (in_fire) begin
      sk_valid_next = 1'b1;
      sk_data_next  = s_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      sk_data_reg   <= '0;
      sk_valid_reg  <= 1'b0;
      ready_reg     <= 1'b0;
    end else begin
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      sk_data_reg   <= sk_data_next;
      sk_valid_reg  <= sk_valid_next;
      ready_reg     <= !sk_valid_next;
    end
  end

endmodule

// File: rtl/ddc_out_framer.sv
// Cuts a decimated sample burst into cfg_spp-sample packets with regenerated timestamps.
// Define DDC_OUT_FRAMER_STATS_EN to add the stat_pkts / stat_bursts counters.
module ddc_out_framer
  import ddc_out_framer_pkg::*;
#(
  parameter int SAMP_W  = SAMP_W_DEF,
  parameter int SPP_W   = SPP_W_DEF,
  parameter int DECIM_W = DECIM_W_DEF,
  parameter int TIME_W  = TIME_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [SPP_W-1:0]   cfg_spp,
  input  logic [DECIM_W-1:0] cfg_decim,
  input  logic [SAMP_W-1:0]  s_tdata,
  input  logic               s_teob,
  input  logic               s_thas_time,
  input  logic [TIME_W-1:0]  s_ttime,
  input  logic               s_tvalid,
  output logic               s_tready,
  output logic [SAMP_W-1:0]  m_tdata,
  output logic               m_tlast,
  output logic               m_teob,
  output logic               m_thas_time,
  output logic [TIME_W-1:0]  m_ttime,
  output logic               m_tvalid,
  input  logic               m_tready
`ifdef DDC_OUT_FRAMER_STATS_EN
  ,
  output logic [31:0]        stat_pkts,
  output logic [31:0]        stat_bursts
`endif
);

  localparam int BEAT_W = SAMP_W + 3 + TIME_W;

  framer_state_t      state_reg, state_next;
  logic [SPP_W-1:0]   spp_reg, cnt_reg, spp_cur, cnt_cur;
  logic [DECIM_W-1:0] decim_reg, decim_cur;
  logic [TIME_W-1:0]  ts_acc_reg, pkt_ts_reg, ts_cur, beat_ts;
  logic               has_time_reg, ht_cur, first, beat_last, accept;
  logic [BEAT_W-1:0]  beat_in, beat_out;

  assign accept = s_tvalid && s_tready && !clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (clear)       state_next = ST_IDLE;
    else if (accept) state_next = s_teob ? ST_IDLE : ST_BURST;
  end

  // The first sample of a burst takes its config and time straight from the
  // inputs so it can be framed in the same cycle it is accepted.
  always_comb begin
    first     = (state_reg == ST_IDLE);
    spp_cur   = first ? cfg_spp : spp_reg;
    decim_cur = first ? DECIM_W'(sat_decim(32'(cfg_decim))) : decim_reg;
    cnt_cur   = first ? '0 : cnt_reg;
    ts_cur    = first ? s_ttime : ts_acc_reg;
    ht_cur    = first ? s_thas_time : has_time_reg;
    beat_last = s_teob || (spp_cur <= SPP_W'(1)) || (cnt_cur == spp_cur - SPP_W'(1));
    beat_ts   = (cnt_cur == '0) ? ts_cur : pkt_ts_reg;
    beat_in   = {s_tdata, beat_last, s_teob, ht_cur, beat_ts};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spp_reg      <= '0;
      decim_reg    <= '0;
      cnt_reg      <= '0;
      ts_acc_reg   <= '0;
      pkt_ts_reg   <= '0;
      has_time_reg <= 1'b0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (accept) begin
      if (first) begin
        spp_reg      <= cfg_spp;
        decim_reg    <= decim_cur;
        has_time_reg <= s_thas_time;
      end
      cnt_reg    <= beat_last ? '0 : cnt_cur + SPP_W'(1);
      ts_acc_reg <= ts_cur + TIME_W'(decim_cur);
      if (cnt_cur == '0) pkt_ts_reg <= ts_cur;
    end
  end

  ddc_out_framer_skid #(.W(BEAT_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .s_data  (beat_in),
    .s_valid (s_tvalid && !clear),
    .s_ready (s_tready),
    .m_data  (beat_out),
    .m_valid (m_tvalid),
    .m_ready (m_tready)
  );

  assign {m_tdata, m_tlast, m_teob, m_thas_time, m_ttime} = beat_out;

`ifdef DDC_OUT_FRAMER_STATS_EN
  logic [31:0] stat_pkts_reg, stat_bursts_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_pkts_reg   <= '0;
      stat_bursts_reg <= '0;
    end else if (clear) begin
      stat_pkts_reg   <= '0;
      stat_bursts_reg <= '0;
    end else if (m_tvalid && m_tready && m_tlast) begin
      stat_pkts_reg <= stat_pkts_reg + 32'd1;
      if (m_teob) stat_bursts_reg <= stat_bursts_reg + 32'd1;
    end
  end

  assign stat_pkts   = stat_pkts_reg;
  assign stat_bursts = stat_bursts_reg;
`endif

endmodule

// File: tb/tb_ddc_out_framer.sv
// Randomized self-checking bench for ddc_out_framer against a burst/packet index model.
module tb_ddc_out_framer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] cfg_spp = '0;
  logic [15:0] cfg_decim = '0;
  logic [31:0] s_tdata = '0;
  logic        s_teob = 1'b0;
  logic        s_thas_time = 1'b0;
  logic [63:0] s_ttime = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tlast, m_teob, m_thas_time, m_tvalid;
  logic [63:0] m_ttime;
  logic        m_tready = 1'b0;
`ifdef DDC_OUT_FRAMER_STATS_EN
  logic [31:0] stat_pkts, stat_bursts;
`endif

  ddc_out_framer dut (
    .clk(clk), .reset(reset), .clear(clear),
    .cfg_spp(cfg_spp), .cfg_decim(cfg_decim),
    .s_tdata(s_tdata), .s_teob(s_teob), .s_thas_time(s_thas_time),
    .s_ttime(s_ttime), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_teob(m_teob),
    .m_thas_time(m_thas_time), .m_ttime(m_ttime), .m_tvalid(m_tvalid),
    .m_tready(m_tready)
`ifdef DDC_OUT_FRAMER_STATS_EN
    , .stat_pkts(stat_pkts), .stat_bursts(stat_bursts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        eob;
    logic        ht;
    logic [63:0] ts;
  } beat_t;

  beat_t       exp_q[$];
  int          pk_sz[$];
  logic [63:0] pk_ts[$];
  bit          pk_eob[$];
  int          pass_cnt = 0, chk_cnt = 0;
  int          cyc = 0, t_in = -1, t_out = -1;
  int          sink_stall_pct = 0;
  int          mpkts = 0, mbursts = 0;

  task automatic check(input bit ok, input string name, input string msg);
    chk_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: %s", name, msg);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_tready = ($urandom_range(99) >= sink_stall_pct);
  end

  // Reference model: a burst is described by its start time, decimation and
  // the index of the first sample of the current packet.
  initial begin
    bit          in_burst = 0, b_ht = 0, prev_stall = 0;
    logic [63:0] b_ts = '0;
    int          b_spp = 1, b_dec = 1, n_in = 0, pkt_start = 0, cur_sz = 0;
    beat_t       e, saved, got;
    forever begin
      @(negedge clk);
      got = {m_tdata, m_tlast, m_teob, m_thas_time, m_ttime};
      if (reset) begin
        exp_q.delete();
        in_burst = 0; cur_sz = 0; mpkts = 0; mbursts = 0; prev_stall = 0;
      end else begin
        if (prev_stall)
          check(got == saved, "stall_hold",
                $sformatf("output changed under backpressure: got %h, held %h", got, saved));
        if (m_tvalid && m_tready) begin
          if (t_out < 0) t_out = cyc;
          if (exp_q.size() == 0) begin
            check(0, "extra_beat", $sformatf("unexpected beat data=%h", m_tdata));
          end else begin
            e = exp_q.pop_front();
            check(m_tdata == e.data && m_tlast == e.last && m_thas_time == e.ht &&
                  m_ttime == e.ts && (!e.last || m_teob == e.eob), "beat",
                  $sformatf("got d=%h l=%0d eob=%0d ht=%0d ts=%0d, want d=%h l=%0d eob=%0d ht=%0d ts=%0d",
                            m_tdata, m_tlast, m_teob, m_thas_time, m_ttime,
                            e.data, e.last, e.eob, e.ht, e.ts));
          end
          cur_sz++;
          if (m_tlast) begin
            $display("pkt size=%0d ts=%0d has_time=%0d eob=%0d", cur_sz, m_ttime, m_thas_time, m_teob);
            pk_sz.push_back(cur_sz); pk_ts.push_back(m_ttime); pk_eob.push_back(m_teob);
            cur_sz = 0; mpkts++;
            if (m_teob) mbursts++;
          end
        end
        prev_stall = m_tvalid && !m_tready && !clear;
        saved = got;
        if (clear) begin
          exp_q.delete();
          in_burst = 0; cur_sz = 0; mpkts = 0; mbursts = 0;
        end else if (s_tvalid && s_tready) begin
          if (t_in < 0) t_in = cyc + 1;
          if (!in_burst) begin
            in_burst = 1; b_ts = s_ttime; b_ht = s_thas_time;
            b_spp = (cfg_spp <= 1) ? 1 : int'(cfg_spp);
            b_dec = (cfg_decim == 0) ? 1 : int'(cfg_decim);
            n_in = 0; pkt_start = 0;
          end
          e.data = s_tdata;
          e.eob  = s_teob;
          e.last = s_teob || (n_in - pkt_start + 1 == b_spp);
          e.ht   = b_ht;
          e.ts   = b_ts + 64'(pkt_start) * 64'(b_dec);
          exp_q.push_back(e);
          n_in++;
          if (e.last) pkt_start = n_in;
          if (s_teob) in_burst = 0;
        end
      end
    end
  end

  task automatic send(input int n, input bit eob_end, input int spp, input int dec,
                      input logic [63:0] ts, input bit ht, input int stall_pct);
    int  i = 0, guard = 0;
    bit  acc;
    while (i < n) begin
      s_tvalid = ($urandom_range(99) >= stall_pct);
      s_tdata  = $urandom;
      s_teob   = eob_end && (i == n - 1);
      if (i == 0) begin
        cfg_spp = 16'(spp); cfg_decim = 16'(dec); s_ttime = ts; s_thas_time = ht;
      end else begin
        cfg_spp = 16'($urandom); cfg_decim = 16'($urandom);
        s_ttime = {$urandom, $urandom}; s_thas_time = 1'($urandom);
      end
      @(negedge clk);
      acc = s_tvalid && s_tready;
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
      if (guard > 20000) begin
        check(0, "send_timeout", $sformatf("only %0d of %0d samples accepted", i, n));
        break;
      end
    end
    s_tvalid = 1'b0;
    s_teob   = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 5000; c++) begin
      if (exp_q.size() == 0 && !m_tvalid) break;
      @(posedge clk);
      #1;
    end
    check(exp_q.size() == 0 && !m_tvalid, "drain",
          $sformatf("%0d beats outstanding, m_tvalid=%0d", exp_q.size(), m_tvalid));
  endtask

  task automatic clear_log();
    pk_sz.delete(); pk_ts.delete(); pk_eob.delete();
    t_in = -1; t_out = -1;
  endtask

  task automatic check_pkt(input int k, input int sz, input logic [63:0] ts, input bit eob);
    if (k >= pk_sz.size())
      check(0, "pkt_missing", $sformatf("packet %0d absent, have %0d", k, pk_sz.size()));
    else
      check(pk_sz[k] == sz && pk_ts[k] == ts && pk_eob[k] == eob, $sformatf("pkt%0d", k),
            $sformatf("got size=%0d ts=%0d eob=%0d, need size=%0d ts=%0d eob=%0d",
                      pk_sz[k], pk_ts[k], pk_eob[k], sz, ts, eob));
  endtask

  task automatic check_count(input int n);
    check(pk_sz.size() == n, "pkt_count", $sformatf("got %0d packets, need %0d", pk_sz.size(), n));
  endtask

  task automatic check_stats();
`ifdef DDC_OUT_FRAMER_STATS_EN
    check(stat_pkts == 32'(mpkts) && stat_bursts == 32'(mbursts), "stats",
          $sformatf("got pkts=%0d bursts=%0d, need %0d/%0d", stat_pkts, stat_bursts, mpkts, mbursts));
`endif
  endtask

  initial begin
    logic [63:0] base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(!s_tready, "reset_tready", $sformatf("s_tready=%0d during reset, need 0", s_tready));
    check({m_tvalid, m_tlast, m_teob, m_thas_time, m_ttime, m_tdata} == '0, "reset_outputs",
          $sformatf("v=%0d l=%0d eob=%0d ht=%0d ts=%0d d=%h, need all 0",
                    m_tvalid, m_tlast, m_teob, m_thas_time, m_ttime, m_tdata));
`ifdef DDC_OUT_FRAMER_STATS_EN
    check(stat_pkts == 0 && stat_bursts == 0, "reset_stats",
          $sformatf("got %0d/%0d, need 0/0", stat_pkts, stat_bursts));
`endif
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check(s_tready, "ready_after_reset", $sformatf("s_tready=%0d, need 1", s_tready));
    @(posedge clk); #1;

`ifdef DDC_OUT_FRAMER_STATS_EN
    clear_log();
    send(10, 1, 4, 1, 0, 1, 0);
    send(10, 1, 4, 1, 0, 1, 0);
    wait_drain();
    check(stat_pkts == 32'd6 && stat_bursts == 32'd2, "stats_literal",
          $sformatf("got %0d/%0d, need 6/2", stat_pkts, stat_bursts));
`endif

    // 10-sample burst at spp=4, decim=2
    clear_log();
    send(10, 1, 4, 2, 64'd100, 1, 0);
    wait_drain();
    check_count(3);
    check_pkt(0, 4, 64'd100, 0);
    check_pkt(1, 4, 64'd108, 0);
    check_pkt(2, 2, 64'd116, 1);
    check(t_out == t_in, "latency", $sformatf("first m_tvalid at edge %0d, need %0d", t_out, t_in));
    check_stats();

    // eob lands exactly on a packet boundary
    clear_log();
    send(8, 1, 4, 2, 64'd0, 0, 0);
    wait_drain();
    check_count(2);
    check_pkt(0, 4, 64'd0, 0);
    check_pkt(1, 4, 64'd8, 1);

    // spp=1 and decim=0
    clear_log();
    send(3, 1, 1, 0, 64'd5, 1, 0);
    wait_drain();
    check_count(3);
    check_pkt(0, 1, 64'd5, 0);
    check_pkt(1, 1, 64'd6, 0);
    check_pkt(2, 1, 64'd7, 1);

    // Long burst with stalls on both sides and a timestamp wrap
    clear_log();
    sink_stall_pct = 25;
    base = 64'hFFFF_FFFF_FFFF_F000;
    send(1028, 1, 256, 13, base, 1, 25);
    wait_drain();
    check_count(5);
    for (int k = 0; k < 4; k++) check_pkt(k, 256, base + 64'(k * 3328), 0);
    check_pkt(4, 4, base + 64'(4 * 3328), 1);
    check_stats();
    sink_stall_pct = 0;

    // clear after two samples, with a beat offered in the clear cycle
    clear_log();
    send(2, 0, 8, 3, 64'd500, 1, 0);
    clear = 1'b1; s_tvalid = 1'b1; s_tdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    clear = 1'b0; s_tvalid = 1'b0;
    @(negedge clk);
    check(!m_tvalid, "clear_flush", $sformatf("m_tvalid=%0d after clear, need 0", m_tvalid));
    @(posedge clk); #1;
    clear_log();
    send(10, 1, 8, 3, 64'd2000, 1, 0);
    wait_drain();
    check_count(2);
    check_pkt(0, 8, 64'd2000, 0);
    check_pkt(1, 2, 64'd2024, 1);
    check_stats();

    // reset in the middle of a packet
    send(5, 0, 4, 1, 64'd0, 1, 0);
    reset = 1'b1;
    @(negedge clk);
    check(!m_tvalid && !s_tready, "reset_mid", $sformatf("m_tvalid=%0d s_tready=%0d, need 0/0", m_tvalid, s_tready));
    @(posedge clk); #1; reset = 1'b0;
    clear_log();
    send(6, 1, 4, 1, 64'd300, 1, 0);
    wait_drain();
    check_count(2);
    check_pkt(0, 4, 64'd300, 0);
    check_pkt(1, 2, 64'd304, 1);

    // random bursts, configs and backpressure
    sink_stall_pct = 30;
    for (int b = 0; b < 20; b++)
      send($urandom_range(1, 40), 1, $urandom_range(0, 9), $urandom_range(0, 5),
           {$urandom, $urandom}, 1'($urandom), 30);
    wait_drain();
    check_stats();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
